alarm_ctrl_nch: RTL and testbench
=================================

Name: alarm_ctrl_nch

Overview:
Parametrised alarm-control core that replaces the single-sensor, single-register arm/trigger logic in the top level. It provides N sensor channels with per-channel masking, a stored passcode, timed exit and entry delays, a wrong-code counter with a lockout period, and latched trip-channel reporting. It sits between the board inputs (switches, keys, sensors) and the video/buzzer enables. oVideo_On drives the decoder-config reset and the VGA overlay.

Parameters:
CODE_W, 10, passcode width in bits.
DEFAULT_CODE, all-ones (CODE_W bits), passcode value after reset.
N_SENSORS, 4, number of sensor channels.
EXIT_DLY_CYC, 50_000_000, cycles from arm request to ARMED; must be >=1.
ENTRY_DLY_CYC, 250_000_000, cycles from a trip to ALARM; must be >=1.
MAX_TRIES, 3, consecutive wrong codes that trigger lockout; must be >=1.
LOCKOUT_CYC, 500_000_000, lockout length in cycles.
CHIRP_LOG2, 23, index of the delay-counter bit that drives oBuzzer during ENTRY_DLY.

Ports:
iCLK  in  1  system clock (50 MHz).
iRST  in  1  asynchronous, active-high reset.
iCode  in  CODE_W  code currently presented on the switches.
iSet_Code  in  1  1-cycle pulse: store iCode as the passcode.
iArm  in  1  1-cycle pulse: start arming.
iEnter  in  1  1-cycle pulse: submit iCode for disarm.
iSense  in  N_SENSORS  raw, asynchronous sensor levels.
iSense_Mask  in  N_SENSORS  1 = channel ignored.
oState  out  3  DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4.
oArmed  out  1  high in EXIT_DLY, ARMED, ENTRY_DLY and ALARM.
oVideo_On  out  1  high in ALARM only.
oBuzzer  out  1  high for solid alarm, chirps in ENTRY_DLY.
oTrip_Chan  out  N_SENSORS  sticky record of the channels that tripped.
oLocked  out  1  lockout is active.
oFail_Cnt  out  clog2(MAX_TRIES+1)  current count of wrong codes.

Behaviour:
- Reset values (asynchronous, iRST=1): state DISARMED, passcode DEFAULT_CODE, sensor baseline 0, delay counter 0, lockout counter 0, oTrip_Chan 0, oFail_Cnt 0, oLocked 0, oVideo_On 0, oBuzzer 0, oArmed 0. Reset is honoured mid-delay and mid-alarm.
- iSense passes through a 2-flop synchroniser, giving sync[]. Trip condition: diff = (sync ^ baseline) & ~iSense_Mask, and diff != 0. A change in either direction counts as a trip. Latency from an iSense edge to ENTRY_DLY: 3 cycles.
- match = (iCode == passcode). This is combinational and is sampled only on iEnter.
- DISARMED:
  - iSet_Code loads the passcode.
  - iArm clears oTrip_Chan, loads the counter with EXIT_DLY_CYC-1 and moves to EXIT_DLY.
  - If iSet_Code and iArm arrive together, the code is stored first and arming proceeds.
  - iEnter is ignored.
- EXIT_DLY: the counter decrements each cycle. At 0 the block latches baseline<=sync and moves to ARMED. Sensors are not evaluated in this state.
- ARMED: a trip sets oTrip_Chan|=diff, loads the counter with ENTRY_DLY_CYC-1 and moves to ENTRY_DLY.
- ENTRY_DLY:
  - Further trips OR into oTrip_Chan.
  - The counter decrements; at 0 the state moves to ALARM.
  - oBuzzer = counter[CHIRP_LOG2].
- ALARM:
  - oVideo_On=1 and oBuzzer=1.
  - Trips continue to OR into oTrip_Chan.
  - The block stays here until a valid disarm.
- Disarm: iEnter with match and oLocked=0 in any armed state moves to DISARMED next cycle. It also clears oFail_Cnt and clears the baseline. oTrip_Chan is retained for review.
- Wrong code: iEnter with a mismatch and oLocked=0 in any armed state increments oFail_Cnt. When the count reaches MAX_TRIES:
  - oLocked<=1 and the lockout counter loads LOCKOUT_CYC-1.
  - The state is forced to ALARM.
  - oFail_Cnt resets to 0.
- Lockout: every iEnter is ignored while oLocked=1. oLocked clears when the lockout counter reaches 0. The state is not changed by lockout expiry.
- Priority within one cycle: valid disarm > trip > delay expiry. A disarm in the same cycle as an ENTRY_DLY expiry goes to DISARMED, not ALARM.
- iArm outside DISARMED is ignored. iSet_Code outside DISARMED is ignored, so the code can never be changed while armed.
- All outputs are registered except oArmed and oVideo_On, which are decoded from the state register.

Decomposition:
- Package alarm_pkg holds:
  - the state enum encoding (3-bit values above);
  - the function clog2;
  - localparams for the delay-counter width, clog2(max(EXIT_DLY_CYC, ENTRY_DLY_CYC)), and the lockout-counter width.
- One natural sub-module, sense_sync_edge: the N-wide 2-flop synchroniser plus the baseline register and the masked diff output. It is reused for future sensor inputs.

Test Plan:
Parameters for all scenarios: N=4, EXIT=4, ENTRY=8, MAX_TRIES=3, LOCKOUT=16, CHIRP_LOG2=1.
1. Reset, then iEnter with iCode=0x3FF -> state stays 0, oFail_Cnt=0. Then iSet_Code with iCode=0x155, iArm -> oState=1 for 4 cycles, then 2; oTrip_Chan=0.
2. ARMED, iSense[2] toggles with mask 0 -> oState=3 three cycles after the edge, oTrip_Chan=4'b0100. After 8 more cycles oState=4, oVideo_On=1, oBuzzer=1.
3. ARMED, mask=4'b0010, iSense[1] toggles -> no state change. iSense[3] toggles -> ENTRY_DLY, oTrip_Chan=4'b1000.
4. ENTRY_DLY, iEnter with 0x155 on the exact expiry cycle -> next oState=0, oVideo_On stays 0, oTrip_Chan retained.
5. ARMED, three iEnter pulses with 0x000 -> oFail_Cnt counts 1, 2, then oLocked=1 and oState=4. iEnter with 0x155 during lockout is ignored. After 16 cycles oLocked=0, and iEnter with 0x155 -> DISARMED.
6. Assert iRST during ALARM with oLocked=1 -> all outputs 0 on the same edge, passcode reverts to 0x3FF.

Source files
------------

// File: rtl/alarm_ctrl_nch_pkg.sv
// alarm_pkg: shared state encoding, width helpers and default counter widths for the alarm core
package alarm_pkg;

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int DLY_W  = clog2(max2(50_000_000, 250_000_000));
    localparam int LOCK_W = clog2(500_000_000);

endpackage

// File: rtl/alarm_ctrl_nch_sense_sync_edge.sv
// sense_sync_edge: N-wide 2-flop synchroniser with a baseline register and masked change detect
module sense_sync_edge #(
    parameter int N = 4
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic [N-1:0] iSense,
    input  logic [N-1:0] iMask,
    input  logic         iLoad,
    input  logic         iClear,
    output logic [N-1:0] oSync,
    output logic [N-1:0] oDiff
);

    logic [N-1:0] s1, s2, base;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1   <= '0;
            s2   <= '0;
            base <= '0;
        end else begin
            s1   <= iSense;
            s2   <= s1;
            base <= iClear ? '0 : iLoad ? s2 : base;
        end
    end

    assign oSync = s2;
    assign oDiff = (s2 ^ base) & ~iMask;

endmodule

// File: rtl/alarm_ctrl_nch.sv
// alarm_ctrl_nch: N-channel alarm controller with passcode, exit/entry delays and wrong-code lockout
module alarm_ctrl_nch
    import alarm_pkg::*;
#(
    parameter int                CODE_W        = 10,
    parameter logic [CODE_W-1:0] DEFAULT_CODE  = '1,
    parameter int                N_SENSORS     = 4,
    parameter int                EXIT_DLY_CYC  = 50_000_000,
    parameter int                ENTRY_DLY_CYC = 250_000_000,
    parameter int                MAX_TRIES     = 3,
    parameter int                LOCKOUT_CYC   = 500_000_000,
    parameter int                CHIRP_LOG2    = 23,
    localparam int               FW            = clog2(MAX_TRIES + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [CODE_W-1:0]    iCode,
    input  logic                 iSet_Code,
    input  logic                 iArm,
    input  logic                 iEnter,
    input  logic [N_SENSORS-1:0] iSense,
    input  logic [N_SENSORS-1:0] iSense_Mask,
    output logic [2:0]           oState,
    output logic                 oArmed,
    output logic                 oVideo_On,
    output logic                 oBuzzer,
    output logic [N_SENSORS-1:0] oTrip_Chan,
    output logic                 oLocked,
    output logic [FW-1:0]        oFail_Cnt
);

    localparam int DW = clog2(max2(EXIT_DLY_CYC, ENTRY_DLY_CYC));
    localparam int LW = clog2(LOCKOUT_CYC);

    state_t                state, state_d;
    logic [DW-1:0]         cnt, cnt_d;
    logic [LW-1:0]         lock_cnt, lock_cnt_d;
    logic [CODE_W-1:0]     code, code_d;
    logic [N_SENSORS-1:0]  trip_d, sync, diff;
    logic [FW-1:0]         fail_d;
    logic                  locked_d, buzzer_d, base_load, base_clr;
    logic                  enter_ok, disarm, wrong, lock_hit, expired;

    sense_sync_edge #(.N(N_SENSORS)) u_sense (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSense (iSense),
        .iMask  (iSense_Mask),
        .iLoad  (base_load),
        .iClear (base_clr),
        .oSync  (sync),
        .oDiff  (diff)
    );

    assign enter_ok = iEnter & ~oLocked & (state != S_DISARMED);
    assign disarm   = enter_ok & (iCode == code);
    assign wrong    = enter_ok & (iCode != code);
    assign lock_hit = wrong & (oFail_Cnt == FW'(MAX_TRIES - 1));
    assign expired  = (cnt == '0);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= S_DISARMED;
        else      state <= state_d;
    end

    // Disarm outranks everything; lockout overrides the normal transition with ALARM.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        code_d     = code;
        trip_d     = oTrip_Chan;
        fail_d     = oFail_Cnt;
        locked_d   = oLocked;
        lock_cnt_d = lock_cnt;
        base_load  = 1'b0;
        base_clr   = 1'b0;
        if (oLocked) begin
            locked_d   = (lock_cnt != '0);
            lock_cnt_d = (lock_cnt != '0) ? lock_cnt - 1'b1 : lock_cnt;
        end
        if (disarm) begin
            state_d  = S_DISARMED;
            fail_d   = '0;
            base_clr = 1'b1;
        end else begin
            fail_d = wrong ? oFail_Cnt + 1'b1 : oFail_Cnt;
            case (state)
                S_DISARMED: begin
                    code_d = iSet_Code ? iCode : code;
                    if (iArm) begin
                        trip_d  = '0;
                        cnt_d   = DW'(EXIT_DLY_CYC - 1);
                        state_d = S_EXIT_DLY;
                    end
                end
                S_EXIT_DLY: begin
                    base_load = expired;
                    state_d   = expired ? S_ARMED : S_EXIT_DLY;
                    cnt_d     = expired ? cnt : cnt - 1'b1;
                end
                S_ARMED: begin
                    if (|diff) begin
                        trip_d  = oTrip_Chan | diff;
                        cnt_d   = DW'(ENTRY_DLY_CYC - 1);
                        state_d = S_ENTRY_DLY;
                    end
                end
                S_ENTRY_DLY: begin
                    trip_d  = oTrip_Chan | diff;
                    state_d = expired ? S_ALARM : S_ENTRY_DLY;
                    cnt_d   = expired ? cnt : cnt - 1'b1;
                end
                S_ALARM:     trip_d = oTrip_Chan | diff;
                default:     state_d = S_DISARMED;
            endcase
            if (lock_hit) begin
                state_d    = S_ALARM;
                locked_d   = 1'b1;
                lock_cnt_d = LW'(LOCKOUT_CYC - 1);
                fail_d     = '0;
            end
        end
    end

    always_comb begin
        oState    = state;
        oArmed    = (state != S_DISARMED);
        oVideo_On = (state == S_ALARM);
        buzzer_d  = (state_d == S_ALARM) | ((state_d == S_ENTRY_DLY) & cnt_d[CHIRP_LOG2]);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt        <= '0;
            lock_cnt   <= '0;
            code       <= DEFAULT_CODE;
            oTrip_Chan <= '0;
            oFail_Cnt  <= '0;
            oLocked    <= 1'b0;
            oBuzzer    <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            lock_cnt   <= lock_cnt_d;
            code       <= code_d;
            oTrip_Chan <= trip_d;
            oFail_Cnt  <= fail_d;
            oLocked    <= locked_d;
            oBuzzer    <= buzzer_d;
        end
    end

endmodule

// File: tb/tb_alarm_ctrl_nch.sv
// tb_alarm_ctrl_nch: directed self-checking bench for alarm_ctrl_nch with short delays
module tb_alarm_ctrl_nch;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [9:0] iCode = '0;
    logic       iSet_Code = 1'b0, iArm = 1'b0, iEnter = 1'b0;
    logic [3:0] iSense = '0, iSense_Mask = '0;
    logic [2:0] oState;
    logic       oArmed, oVideo_On, oBuzzer, oLocked;
    logic [3:0] oTrip_Chan;
    logic [1:0] oFail_Cnt;

    int vectors = 0;
    int miscompares = 0;

    alarm_ctrl_nch #(
        .CODE_W(10), .N_SENSORS(4), .EXIT_DLY_CYC(4), .ENTRY_DLY_CYC(8),
        .MAX_TRIES(3), .LOCKOUT_CYC(16), .CHIRP_LOG2(1)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iCode(iCode), .iSet_Code(iSet_Code),
        .iArm(iArm), .iEnter(iEnter), .iSense(iSense), .iSense_Mask(iSense_Mask),
        .oState(oState), .oArmed(oArmed), .oVideo_On(oVideo_On), .oBuzzer(oBuzzer),
        .oTrip_Chan(oTrip_Chan), .oLocked(oLocked), .oFail_Cnt(oFail_Cnt)
    );

    always #5 iCLK = ~iCLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enter(input logic [9:0] c);
        iCode = c; iEnter = 1'b1; step(1); iEnter = 1'b0;
    endtask

    task automatic arm();
        iArm = 1'b1; step(1); iArm = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(oState), 0);
        chk({tag, "_armed"}, 32'(oArmed), 0);
        chk({tag, "_video"}, 32'(oVideo_On), 0);
        chk({tag, "_buzzer"}, 32'(oBuzzer), 0);
        chk({tag, "_trip"}, 32'(oTrip_Chan), 0);
        chk({tag, "_locked"}, 32'(oLocked), 0);
        chk({tag, "_fail"}, 32'(oFail_Cnt), 0);
    endtask

    initial begin
        step(2);
        chk_all_zero("reset");
        iRST = 1'b0;
        step(1);
        // 1: enter ignored while disarmed, then store 0x155 and arm
        enter(10'h3FF);
        chk("t1_enter_ignored_state", 32'(oState), 0);
        chk("t1_enter_ignored_fail", 32'(oFail_Cnt), 0);
        iCode = 10'h155; iSet_Code = 1'b1; step(1); iSet_Code = 1'b0;
        arm();
        for (int i = 0; i < 4; i++) begin
            chk("t1_exit_dly", 32'(oState), 1);
            step(1);
        end
        chk("t1_armed", 32'(oState), 2);
        chk("t1_armed_flag", 32'(oArmed), 1);
        chk("t1_trip", 32'(oTrip_Chan), 0);
        // 2: unmasked trip on channel 2, entry delay, alarm
        iSense = 4'b0100;
        step(2);
        chk("t2_pre_entry", 32'(oState), 2);
        step(1);
        chk("t2_entry", 32'(oState), 3);
        chk("t2_trip", 32'(oTrip_Chan), 4'b0100);
        chk("t2_chirp_hi", 32'(oBuzzer), 1);
        step(2);
        chk("t2_chirp_lo", 32'(oBuzzer), 0);
        step(5);
        chk("t2_still_entry", 32'(oState), 3);
        step(1);
        chk("t2_alarm", 32'(oState), 4);
        chk("t2_video", 32'(oVideo_On), 1);
        chk("t2_buzzer", 32'(oBuzzer), 1);
        enter(10'h155);
        chk("t2_disarm", 32'(oState), 0);
        chk("t2_trip_kept", 32'(oTrip_Chan), 4'b0100);
        chk("t2_video_off", 32'(oVideo_On), 0);
        // 3: masked channel ignored, unmasked channel trips
        iSense_Mask = 4'b0010;
        arm();
        step(4);
        chk("t3_armed", 32'(oState), 2);
        iSense = 4'b0110;
        step(4);
        chk("t3_masked", 32'(oState), 2);
        iSense = 4'b1110;
        step(3);
        chk("t3_entry", 32'(oState), 3);
        chk("t3_trip", 32'(oTrip_Chan), 4'b1000);
        // 4: disarm on the exact expiry cycle beats the move to ALARM
        step(7);
        chk("t4_last_entry", 32'(oState), 3);
        enter(10'h155);
        chk("t4_disarm", 32'(oState), 0);
        chk("t4_video", 32'(oVideo_On), 0);
        chk("t4_trip_kept", 32'(oTrip_Chan), 4'b1000);
        // 5: three wrong codes lock out, lockout ignores enter, expiry then disarm
        arm();
        step(4);
        chk("t5_armed", 32'(oState), 2);
        enter(10'h000);
        chk("t5_fail1", 32'(oFail_Cnt), 1);
        chk("t5_fail1_state", 32'(oState), 2);
        enter(10'h000);
        chk("t5_fail2", 32'(oFail_Cnt), 2);
        enter(10'h000);
        chk("t5_locked", 32'(oLocked), 1);
        chk("t5_lock_alarm", 32'(oState), 4);
        chk("t5_fail_reset", 32'(oFail_Cnt), 0);
        enter(10'h155);
        chk("t5_ignored_state", 32'(oState), 4);
        chk("t5_ignored_fail", 32'(oFail_Cnt), 0);
        step(14);
        chk("t5_still_locked", 32'(oLocked), 1);
        step(1);
        chk("t5_unlocked", 32'(oLocked), 0);
        chk("t5_unlock_state", 32'(oState), 4);
        enter(10'h155);
        chk("t5_disarm", 32'(oState), 0);
        // 6: asynchronous reset during locked alarm, passcode reverts to default
        arm();
        step(4);
        enter(10'h000);
        enter(10'h000);
        enter(10'h000);
        chk("t6_pre_locked", 32'(oLocked), 1);
        chk("t6_pre_alarm", 32'(oState), 4);
        iRST = 1'b1;
        #1;
        chk_all_zero("t6_async");
        step(1);
        iRST = 1'b0;
        step(1);
        arm();
        enter(10'h155);
        chk("t6_old_code_wrong", 32'(oFail_Cnt), 1);
        chk("t6_old_code_state", 32'(oState), 1);
        enter(10'h3FF);
        chk("t6_default_code", 32'(oState), 0);
        chk("t6_fail_clear", 32'(oFail_Cnt), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
